// File: rtl/tcdm_filter_pkg.sv
// Shared register map, bit indices and rule word layout for the TCDM filter config unit.
package tcdm_filter_pkg;

    localparam logic [7:0] OFF_CTRL      = 8'h00;
    localparam logic [7:0] OFF_STATUS    = 8'h04;
    localparam logic [7:0] OFF_ERR_ADDR  = 8'h08;
    localparam logic [7:0] OFF_ERR_INFO  = 8'h0C;
    localparam logic [7:0] OFF_RULE_BASE = 8'h40;

    localparam int CTRL_FILTER_EN    = 0;
    localparam int CTRL_LOCK         = 1;
    localparam int CTRL_IRQ_EN       = 2;
    localparam int STATUS_ERR_VALID  = 0;
    localparam int STATUS_OVERFLOW   = 1;
    localparam int STATUS_CNT_LSB    = 8;

    localparam logic [1:0] AREA_L2      = 2'd0;
    localparam logic [1:0] AREA_CLUSTER = 2'd1;
    localparam logic [1:0] AREA_ROM     = 2'd2;
    localparam logic [1:0] AREA_APB     = 2'd3;

    typedef struct packed {
        logic [1:0]  area;
        logic [14:0] base;
        logic [13:0] size;
        logic        active;
    } rule_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

endpackage

// File: rtl/tcdm_filter_err_log.sv
// Violation capture: first address/direction, saturating count, overflow flag and registered irq.
module tcdm_filter_err_log #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  error_i,
    input  logic [ADDR_WIDTH-1:0] err_add_i,
    input  logic                  err_wen_i,
    input  logic                  clr_i,
    input  logic                  irq_en_i,
    output logic                  err_valid_o,
    output logic                  overflow_o,
    output logic [7:0]            err_count_o,
    output logic [ADDR_WIDTH-1:0] err_addr_o,
    output logic                  err_wen_o,
    output logic                  irq_o
);

    logic       valid_base, ovf_base, valid_d, ovf_d, capture;
    logic [7:0] cnt_base, cnt_d;

    // A clear in the same cycle as an error is applied first, so the error is logged as new.
    always_comb begin
        valid_base = clr_i ? 1'b0 : err_valid_o;
        ovf_base   = clr_i ? 1'b0 : overflow_o;
        cnt_base   = clr_i ? 8'd0 : err_count_o;
        valid_d    = valid_base;
        ovf_d      = ovf_base;
        cnt_d      = cnt_base;
        capture    = 1'b0;
        if (error_i) begin
            if (!valid_base) begin
                capture = 1'b1;
                valid_d = 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
            if (cnt_base != 8'hFF) cnt_d = cnt_base + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid_o <= 1'b0;
            overflow_o  <= 1'b0;
            err_count_o <= 8'd0;
            err_addr_o  <= '0;
            err_wen_o   <= 1'b0;
            irq_o       <= 1'b0;
        end else begin
            err_valid_o <= valid_d;
            overflow_o  <= ovf_d;
            err_count_o <= cnt_d;
            irq_o       <= valid_d & irq_en_i;
            if (capture) begin
                err_addr_o <= err_add_i;
                err_wen_o  <= err_wen_i;
            end
        end
    end

endmodule

// File: rtl/tcdm_filter_cfg_unit.sv
// APB register block for the TCDM address filter: rules, enable, one-shot lock, optional error log.
// Error logging is built only when TCDM_FILTER_ERR_LOG_EN is defined.
//   state    | meaning
//   UNLOCKED | rules and CTRL[1:0] writable
//   LOCKED   | rules and CTRL[1:0] frozen until rst_n
module tcdm_filter_cfg_unit
    import tcdm_filter_pkg::*;
#(
    parameter int N_RULES        = 8,
    parameter int APB_ADDR_WIDTH = 12,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [APB_ADDR_WIDTH-1:0] paddr_i,
    input  logic [31:0]               pwdata_i,
    input  logic                      pwrite_i,
    input  logic                      psel_i,
    input  logic                      penable_i,
    output logic [31:0]               prdata_o,
    output logic                      pready_o,
    output logic                      pslverr_o,
    output logic [N_RULES-1:0][31:0]  rules_o,
    output logic                      filter_en_o,
    input  logic                      error_i,
    input  logic [ADDR_WIDTH-1:0]     err_add_i,
    input  logic                      err_wen_i,
    output logic                      irq_o
);

    lock_state_t             lock_state;
    logic                    filter_en_q;
    rule_t [N_RULES-1:0]     rules_q;
    logic [7:0]              off;
    logic [3:0]              rule_idx;
    logic                    access, aligned, locked, wr_ok, ctrl_wr, rule_wr;
    logic                    hit_ctrl, hit_status, hit_err_addr, hit_err_info, hit_rule;
    logic [31:0]             rd_data;
    logic                    slv_err;
    logic                    err_valid, overflow, err_wen, irq_en_rd;
    logic [7:0]              err_count;
    logic [ADDR_WIDTH-1:0]   err_addr;
    logic                    unused_paddr;

    assign unused_paddr = ^paddr_i[APB_ADDR_WIDTH-1:8];
    assign off          = paddr_i[7:0];
    assign rule_idx     = off[5:2];
    assign access       = psel_i & penable_i;
    assign aligned      = (off[1:0] == 2'b00);
    assign locked       = (lock_state == LOCKED);
    assign hit_ctrl     = (off == OFF_CTRL);
    assign hit_status   = (off == OFF_STATUS);
    assign hit_err_addr = (off == OFF_ERR_ADDR);
    assign hit_err_info = (off == OFF_ERR_INFO);
    assign hit_rule     = (off[7:6] == OFF_RULE_BASE[7:6]) && (int'(rule_idx) < N_RULES);

    always_comb begin
        rd_data = '0;
        slv_err = 1'b0;
        if (access) begin
            if (!aligned) begin
                slv_err = 1'b1;
            end else if (hit_ctrl) begin
                slv_err = pwrite_i & locked;
                rd_data = {29'd0, irq_en_rd, locked, filter_en_q};
            end else if (hit_status) begin
                rd_data = {16'd0, err_count, 6'd0, overflow, err_valid};
            end else if (hit_err_addr) begin
                slv_err = pwrite_i;
                rd_data = 32'(err_addr);
            end else if (hit_err_info) begin
                slv_err = pwrite_i;
                rd_data = {31'd0, err_wen};
            end else if (hit_rule) begin
                slv_err = pwrite_i & locked;
                for (int i = 0; i < N_RULES; i++) begin
                    if (rule_idx == 4'(i)) rd_data = rules_q[i];
                end
            end else begin
                slv_err = 1'b1;
            end
        end
    end

    assign wr_ok   = access & pwrite_i & ~slv_err;
    assign ctrl_wr = wr_ok & hit_ctrl;
    assign rule_wr = wr_ok & hit_rule;

    assign prdata_o    = (pwrite_i || slv_err) ? 32'd0 : rd_data;
    assign pslverr_o   = slv_err;
    assign pready_o    = 1'b1;
    assign rules_o     = rules_q;
    assign filter_en_o = filter_en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_state  <= UNLOCKED;
            filter_en_q <= 1'b0;
        end else begin
            case (lock_state)
                UNLOCKED: if (ctrl_wr) begin
                    filter_en_q <= pwdata_i[CTRL_FILTER_EN];
                    if (pwdata_i[CTRL_LOCK]) lock_state <= LOCKED;
                end
                LOCKED: lock_state <= LOCKED;
                default: lock_state <= UNLOCKED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rules_q <= '0;
        end else if (rule_wr) begin
            for (int i = 0; i < N_RULES; i++) begin
                if (rule_idx == 4'(i)) rules_q[i] <= rule_t'(pwdata_i);
            end
        end
    end

`ifdef TCDM_FILTER_ERR_LOG_EN
    logic irq_en_q, irq_en_d, ctrl_wr_any, status_clr;

    // irq_en stays writable after lock, even though the same access reports an error.
    assign ctrl_wr_any = access & pwrite_i & aligned & hit_ctrl;
    assign irq_en_d    = ctrl_wr_any ? pwdata_i[CTRL_IRQ_EN] : irq_en_q;
    assign status_clr  = wr_ok & hit_status & pwdata_i[STATUS_ERR_VALID];
    assign irq_en_rd   = irq_en_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq_en_q <= 1'b0;
        else        irq_en_q <= irq_en_d;
    end

    tcdm_filter_err_log #(.ADDR_WIDTH(ADDR_WIDTH)) i_err_log (
        .clk         (clk),
        .rst_n       (rst_n),
        .error_i     (error_i),
        .err_add_i   (err_add_i),
        .err_wen_i   (err_wen_i),
        .clr_i       (status_clr),
        .irq_en_i    (irq_en_d),
        .err_valid_o (err_valid),
        .overflow_o  (overflow),
        .err_count_o (err_count),
        .err_addr_o  (err_addr),
        .err_wen_o   (err_wen),
        .irq_o       (irq_o)
    );
`else
    logic unused_err;

    assign unused_err = ^{error_i, err_add_i, err_wen_i};
    assign irq_en_rd  = 1'b0;
    assign err_valid  = 1'b0;
    assign overflow   = 1'b0;
    assign err_count  = 8'd0;
    assign err_addr   = '0;
    assign err_wen    = 1'b0;
    assign irq_o      = 1'b0;
`endif

endmodule
